cpu_data_mem_responder: RTL and testbench
=========================================

Name: cpu_data_mem_responder

Overview:
Word-addressed data memory that answers the multicycle control unit's memory strobes. The control unit starts a request with a read strobe (load into MDR) or a write strobe (store from register file). This block latches the request, inserts a fixed number of wait states, performs the access and returns a one-cycle ready pulse with read data. It sits between the control unit/datapath and the data storage array, replacing the zero-latency memory so the controller can be verified against a slow responder.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 8, word address width; depth = 2**ADDR_W words; every address is valid
WAIT_CYCLES, 2, wait-state cycles between request capture and completion; legal range 0..15

Ports:
Clk  input  1  system clock; all state changes on its rising edge
Reset  input  1  asynchronous, active-low reset (asserted when 0)
MemRead  input  1  read request strobe; sampled only in IDLE
MemWrite  input  1  write request strobe; sampled only in IDLE
Addr  input  ADDR_W  word address; captured with the request
WriteData  input  DATA_W  store data; captured with the request
ReadData  output  DATA_W  registered read data; holds its value until the next read completes
MemReady  output  1  one-cycle completion pulse
MemBusy  output  1  high while a request is in progress (state != IDLE)
MemError  output  1  sticky protocol-error flag

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, wait counter=0, latched address/data/op=0, ReadData=0, MemReady=0, MemBusy=0, MemError=0. The storage array is not cleared. A pending write that has not completed is discarded and the array is unchanged.
- States: IDLE, WAIT, DONE.
- IDLE:
  - MemRead xor MemWrite at an edge: latch Addr, WriteData and op. If WAIT_CYCLES>0, go to WAIT with counter=WAIT_CYCLES; otherwise perform the access and go to DONE.
  - MemRead and MemWrite both high: no access, MemError<=1, stay in IDLE.
  - Neither strobe high: stay in IDLE.
- WAIT: counter decrements every edge. At the edge where counter==1, perform the access and go to DONE. WAIT therefore lasts exactly WAIT_CYCLES cycles.
- Access, on the edge entering DONE:
  - write: mem[addr]<=data.
  - read: ReadData<=mem[addr].
- DONE: MemReady=1 for exactly this cycle. The next edge always returns to IDLE; strobes are not sampled in DONE.
- Latency: request sampled at edge E, MemReady high in the cycle after edge E+WAIT_CYCLES (E+1 when WAIT_CYCLES=0). Minimum request-to-request spacing is WAIT_CYCLES+2 edges.
- Strobes asserted in WAIT or DONE are ignored; there is no queueing and no error. The requester holds its strobe only until MemReady.
- Addr and WriteData changes after capture do not affect the in-flight access.
- MemReady, ReadData and MemError are registered; MemBusy is decoded from state, glitch-free.
- MemError clears only on reset.

Optional Feature:
DMEM_WRITE_ECHO_EN:
- Defined: on write completion ReadData<=latched WriteData in the same edge as the array write, so the datapath observes the stored word.
- Undefined: ReadData is unchanged by writes and updates only on read completion.

Test Plan:
1. Reset=0 mid-WAIT of write 0xDEADBEEF to addr 0x10, release, read addr 0x10 -> all outputs 0 immediately on reset; read returns the prior contents, not 0xDEADBEEF.
2. WAIT_CYCLES=2: write 0x12345678 to 0x05 at edge E, then read 0x05 -> MemBusy high E+1..E+3, MemReady pulses in cycle after E+2; read returns 0x12345678 with MemReady.
3. Back-to-back: MemRead held high continuously at addr 0x01 (contents 0xA5A5A5A5) -> one completion every 4 edges; MemReady never high two consecutive cycles.
4. MemRead=MemWrite=1 in IDLE at addr 0x02 -> MemError=1 next cycle and stays 1; MemBusy stays 0; mem[0x02] unchanged; a following legal read completes normally.
5. MemWrite pulsed during WAIT of a read to addr 0x03 (contents 0x0) with WriteData=0xFFFFFFFF -> ignored; mem[0x03] stays 0x0; MemError stays 0.
6. WAIT_CYCLES=0: read 0x07 (contents 0x00000042) -> MemReady in cycle after the sampling edge, ReadData=0x00000042; write 0x99 to 0x07 -> ReadData=0x99 only with DMEM_WRITE_ECHO_EN defined, else stays 0x42.

Source files
------------

// File: rtl/cpu_data_mem_responder_if.sv
// Request/response bus between the multicycle control unit and the data memory responder.
interface cpu_data_mem_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              MemReady;
  logic              MemBusy;
  logic              MemError;

  // Control unit / datapath side
  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, MemReady, MemBusy, MemError
  );

  // Memory responder side
  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, MemReady, MemBusy, MemError
  );
endinterface

// File: rtl/cpu_data_mem_responder.sv
// Word-addressed data memory with a fixed number of wait states per access.
// A request (read xor write strobe) is captured in IDLE, held for WAIT_CYCLES
// cycles, performed on the edge entering DONE, and acknowledged by a
// one-cycle MemReady pulse. Both strobes at once set the sticky MemError.
// Optional macro DMEM_WRITE_ECHO_EN: a completing write also loads ReadData
// with the stored word.
module cpu_data_mem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  cpu_data_mem_responder_if.slave   bus
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_W   = 4;
  localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              op_wr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_c;
  logic              access_c;
  logic [ADDR_W-1:0] acc_addr_c;
  logic [DATA_W-1:0] acc_data_c;
  logic              acc_wr_c;

  // Access decode; with zero wait states the access happens straight from IDLE
  // using the live bus, otherwise from the latched request.
  always_comb begin
    req_c      = 1'b0;
    access_c   = 1'b0;
    acc_addr_c = addr_q;
    acc_data_c = data_q;
    acc_wr_c   = op_wr_q;
    if (state == S_IDLE) begin
      req_c      = bus.MemRead ^ bus.MemWrite;
      access_c   = req_c && NO_WAIT;
      acc_addr_c = bus.Addr;
      acc_data_c = bus.WriteData;
      acc_wr_c   = bus.MemWrite;
    end else if (state == S_WAIT) begin
      access_c   = (cnt == CNT_W'(1));
    end
  end

  // Storage array write port; never reset, and gated so nothing lands while Reset is low.
  always_ff @(posedge Clk) begin
    if (Reset && access_c && acc_wr_c) begin
      mem[acc_addr_c] <= acc_data_c;
    end
  end

  // Request FSM with registered ready, read data and sticky error.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.MemRead && bus.MemWrite) begin
            err_q <= 1'b1;
          end else if (req_c) begin
            addr_q  <= bus.Addr;
            data_q  <= bus.WriteData;
            op_wr_q <= bus.MemWrite;
            if (NO_WAIT) begin
              state   <= S_DONE;
              ready_q <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state   <= S_DONE;
            ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      // Read data update on the edge entering DONE
      if (access_c) begin
        if (!acc_wr_c) begin
          rdata_q <= mem[acc_addr_c];
        end
`ifdef DMEM_WRITE_ECHO_EN
        else begin
          rdata_q <= acc_data_c;
        end
`endif
      end
    end
  end

  // Output drive; busy is a pure decode of the state register.
  assign bus.ReadData = rdata_q;
  assign bus.MemReady = ready_q;
  assign bus.MemError = err_q;
  assign bus.MemBusy  = (state != S_IDLE);

endmodule

// File: tb/tb_cpu_data_mem_responder.sv
// Directed bench for cpu_data_mem_responder: one instance with two wait
// states and one with zero wait states.
module tb_cpu_data_mem_responder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cpu_data_mem_responder_if #(.DATA_W(32), .ADDR_W(8)) bus_a ();
  cpu_data_mem_responder_if #(.DATA_W(32), .ADDR_W(8)) bus_b ();

  cpu_data_mem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus_a)
  );

  cpu_data_mem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge, hold it through one rising edge, then drop strobes.
  task automatic start(input bit b, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    if (b) begin
      bus_b.MemRead = rd; bus_b.MemWrite = wr; bus_b.Addr = a; bus_b.WriteData = d;
    end else begin
      bus_a.MemRead = rd; bus_a.MemWrite = wr; bus_a.Addr = a; bus_a.WriteData = d;
    end
    @(posedge clk);
    #1;
    if (b) begin
      bus_b.MemRead = 1'b0; bus_b.MemWrite = 1'b0;
    end else begin
      bus_a.MemRead = 1'b0; bus_a.MemWrite = 1'b0;
    end
  endtask

  // Count negedges until MemReady (bounded); n stays 0 on timeout.
  task automatic wait_rdy(input bit b, output int n, output logic [31:0] rdata);
    n = 0;
    rdata = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (b ? bus_b.MemReady : bus_a.MemReady) begin
        n = i;
        rdata = b ? bus_b.ReadData : bus_a.ReadData;
        break;
      end
    end
  endtask

  task automatic txn(input string tag, input bit b, input logic rd, input logic wr,
                     input logic [7:0] a, input logic [31:0] d, input int exp_lat,
                     output logic [31:0] rdata);
    int n;
    start(b, rd, wr, a, d);
    wait_rdy(b, n, rdata);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
  endtask

  logic [31:0] rdata;
  logic        rec [16];
  int          n;
  int          cnt_rdy;
  int          first_idx;
  int          last_idx;
  int          bad_gap;
  int          consec;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_a.MemRead = 1'b0; bus_a.MemWrite = 1'b0; bus_a.Addr = '0; bus_a.WriteData = '0;
    bus_b.MemRead = 1'b0; bus_b.MemWrite = 1'b0; bus_b.Addr = '0; bus_b.WriteData = '0;

    #12;
    check("rst_rdata", bus_a.ReadData, 32'h0);
    check("rst_ready", 32'(bus_a.MemReady), 32'h0);
    check("rst_busy",  32'(bus_a.MemBusy),  32'h0);
    check("rst_err",   32'(bus_a.MemError), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a write's wait states discards the write
    txn("t1_pre_wr", 1'b0, 1'b0, 1'b1, 8'h10, 32'h1111_1111, 3, rdata);
    txn("t1_pre_rd", 1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 3, rdata);
    check("t1_pre_data", rdata, 32'h1111_1111);
    start(1'b0, 1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF);
    check("t1_busy_before", 32'(bus_a.MemBusy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_rdata", bus_a.ReadData, 32'h0);
    check("t1_rst_busy",  32'(bus_a.MemBusy),  32'h0);
    check("t1_rst_ready", 32'(bus_a.MemReady), 32'h0);
    check("t1_rst_err",   32'(bus_a.MemError), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    txn("t1_rd", 1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 3, rdata);
    check("t1_data", rdata, 32'h1111_1111);

    // Two wait states: busy/ready timing of a write, then read back
    start(1'b0, 1'b0, 1'b1, 8'h05, 32'h1234_5678);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("t2_busy%0d", i),  32'(bus_a.MemBusy),  (i <= 3) ? 32'h1 : 32'h0);
      check($sformatf("t2_ready%0d", i), 32'(bus_a.MemReady), (i == 3) ? 32'h1 : 32'h0);
    end
    txn("t2_rd", 1'b0, 1'b1, 1'b0, 8'h05, 32'h0, 3, rdata);
    check("t2_data", rdata, 32'h1234_5678);

    // Read strobe held continuously: one completion every four edges
    txn("t3_wr", 1'b0, 1'b0, 1'b1, 8'h01, 32'hA5A5_A5A5, 3, rdata);
    @(negedge clk);
    bus_a.Addr = 8'h01;
    bus_a.MemRead = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      rec[i] = bus_a.MemReady;
      if (bus_a.MemReady) check($sformatf("t3_data%0d", i), bus_a.ReadData, 32'hA5A5_A5A5);
    end
    bus_a.MemRead = 1'b0;
    cnt_rdy = 0; first_idx = -1; last_idx = -1; bad_gap = 0; consec = 0;
    for (int i = 0; i < 16; i++) begin
      if (rec[i]) begin
        cnt_rdy++;
        if (first_idx < 0) first_idx = i;
        if (last_idx >= 0 && (i - last_idx) != 4) bad_gap++;
        last_idx = i;
      end
      if (i > 0 && rec[i] && rec[i-1]) consec++;
    end
    check("t3_count",  32'(cnt_rdy),   32'd4);
    check("t3_first",  32'(first_idx), 32'd2);
    check("t3_gap",    32'(bad_gap),   32'd0);
    check("t3_consec", 32'(consec),    32'd0);
    repeat (2) @(negedge clk);

    // Write strobe during a read's wait states is ignored
    txn("t5_wr", 1'b0, 1'b0, 1'b1, 8'h03, 32'h0, 3, rdata);
    start(1'b0, 1'b1, 1'b0, 8'h03, 32'h0);
    bus_a.MemWrite = 1'b1;
    bus_a.WriteData = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 bus_a.MemWrite = 1'b0;
    wait_rdy(1'b0, n, rdata);
    check("t5_lat",  32'(n), 32'd2);
    check("t5_data", rdata, 32'h0);
    check("t5_err",  32'(bus_a.MemError), 32'h0);
    txn("t5_rd", 1'b0, 1'b1, 1'b0, 8'h03, 32'h0, 3, rdata);
    check("t5_mem", rdata, 32'h0);

    // Both strobes at once: sticky error, no access
    txn("t4_wr", 1'b0, 1'b0, 1'b1, 8'h02, 32'h2222_2222, 3, rdata);
    start(1'b0, 1'b1, 1'b1, 8'h02, 32'h3333_3333);
    @(negedge clk);
    check("t4_err",  32'(bus_a.MemError), 32'h1);
    check("t4_busy", 32'(bus_a.MemBusy),  32'h0);
    repeat (2) @(negedge clk);
    check("t4_err_hold",  32'(bus_a.MemError), 32'h1);
    check("t4_busy_hold", 32'(bus_a.MemBusy),  32'h0);
    txn("t4_rd", 1'b0, 1'b1, 1'b0, 8'h02, 32'h0, 3, rdata);
    check("t4_mem", rdata, 32'h2222_2222);
    check("t4_err_after", 32'(bus_a.MemError), 32'h1);

    // Zero wait states, including write echo behaviour
    txn("t6_wr42", 1'b1, 1'b0, 1'b1, 8'h07, 32'h0000_0042, 1, rdata);
    txn("t6_rd42", 1'b1, 1'b1, 1'b0, 8'h07, 32'h0, 1, rdata);
    check("t6_data42", rdata, 32'h0000_0042);
    txn("t6_wr99", 1'b1, 1'b0, 1'b1, 8'h07, 32'h0000_0099, 1, rdata);
`ifdef DMEM_WRITE_ECHO_EN
    check("t6_echo", rdata, 32'h0000_0099);
`else
    check("t6_echo", rdata, 32'h0000_0042);
`endif
    @(negedge clk);
    check("t6_ready_pulse", 32'(bus_b.MemReady), 32'h0);
    txn("t6_rd99", 1'b1, 1'b1, 1'b0, 8'h07, 32'h0, 1, rdata);
    check("t6_data99", rdata, 32'h0000_0099);
    check("t6_err", 32'(bus_b.MemError), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
